reorder_buffer: RTL and testbench

//  In-order completion unit that drives the register file's ARF-update (commit) port, updateEnA/B and updateAddrA/B.
//  Up to 2 instructions are allocated per cycle at decode, in program order, A older than B.

---
 rtl/reorder_buffer_pkg.sv | 7 +
 rtl/reorder_buffer_retire_select.sv | 37 +++
 rtl/reorder_buffer.sv | 158 +++++++++++++++
 tb/tb_reorder_buffer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared sizing for the reorder buffer and the register-file tag logic.
package reorder_buffer_pkg;
    localparam int ROB_DEPTH  = 8;              // ROB entries, power of two
    localparam int ROB_TAG_W  = 3;              // log2(ROB_DEPTH)
    localparam int ROB_CNT_W  = ROB_TAG_W + 1;  // occupancy counter 0..ROB_DEPTH
    localparam int GPR_ADDR_W = 5;              // architectural register address
endpackage

// File: rtl/reorder_buffer_retire_select.sv
// Retire selection: decides whether the head entry and the one after it
// may retire this cycle. The second slot is held back when both entries
// write the same GPR, so the two ARF copies never target one register
// in the same cycle.
module rob_retire_select
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH  = ROB_DEPTH,
    parameter int TAG_W  = ROB_TAG_W,
    parameter int ADDR_W = GPR_ADDR_W
) (
    input  logic [DEPTH-1:0]             i_valid,
    input  logic [DEPTH-1:0]             i_finished,
    input  logic [DEPTH-1:0]             i_dest_en,
    input  logic [DEPTH-1:0][ADDR_W-1:0] i_dest,
    input  logic [TAG_W-1:0]             i_head,
    output logic [TAG_W-1:0]             o_head1,
    output logic                         o_r0,
    output logic                         o_r1
);
    logic [TAG_W-1:0] w_head1;
    logic             w_clash;

    // head+1 wraps naturally because the tag is exactly log2(DEPTH) wide
    assign w_head1 = i_head + TAG_W'(1);
    assign o_head1 = w_head1;

    // Same destination on both candidates forces them onto separate cycles
    assign w_clash = i_dest_en[i_head] & i_dest_en[w_head1] &
                     (i_dest[i_head] == i_dest[w_head1]);

    // r1 only ever follows r0: retirement is strictly in order
    always_comb begin
        o_r0 = i_valid[i_head] & i_finished[i_head];
        o_r1 = o_r0 & i_valid[w_head1] & i_finished[w_head1] & ~w_clash;
    end
endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order allocation of up to two entries per cycle,
// out-of-order finish marking, in-order retire of up to two entries per
// cycle driving the ARF-update port of the register file.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH  = ROB_DEPTH,
    parameter int TAG_W  = ROB_TAG_W,
    parameter int ADDR_W = GPR_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_en_A,
    input  logic              alloc_en_B,
    input  logic              alloc_dest_en_A,
    input  logic              alloc_dest_en_B,
    input  logic [ADDR_W-1:0] alloc_dest_A,
    input  logic [ADDR_W-1:0] alloc_dest_B,
    output logic              alloc_ready_A,
    output logic              alloc_ready_B,
    output logic [TAG_W-1:0]  alloc_tag_A,
    output logic [TAG_W-1:0]  alloc_tag_B,
    input  logic              finish_en_A,
    input  logic              finish_en_B,
    input  logic [TAG_W-1:0]  finish_tag_A,
    input  logic [TAG_W-1:0]  finish_tag_B,
    output logic              updateEnA,
    output logic              updateEnB,
    output logic [ADDR_W-1:0] updateAddrA,
    output logic [ADDR_W-1:0] updateAddrB,
    output logic              rob_empty,
    output logic              rob_full
);
    localparam int                CNT_W   = TAG_W + 1;
    localparam logic [CNT_W-1:0]  L_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  L_DM1   = CNT_W'(DEPTH - 1);

    logic [DEPTH-1:0]             r_valid;
    logic [DEPTH-1:0]             r_finished;
    logic [DEPTH-1:0]             r_dest_en;
    logic [DEPTH-1:0][ADDR_W-1:0] r_dest;
    logic [TAG_W-1:0]             r_head;
    logic [TAG_W-1:0]             r_tail;
    logic [CNT_W-1:0]             r_count;
    logic                         r_upd_en_a;
    logic                         r_upd_en_b;
    logic [ADDR_W-1:0]            r_upd_addr_a;
    logic [ADDR_W-1:0]            r_upd_addr_b;

    logic                         w_acc_a;
    logic                         w_acc_b;
    logic                         w_r0;
    logic                         w_r1;
    logic [TAG_W-1:0]             w_head1;
    logic                         w_wr_a;
    logic                         w_wr_b;
    logic [CNT_W-1:0]             w_n_alloc;
    logic [CNT_W-1:0]             w_n_ret;

    rob_retire_select #(
        .DEPTH  (DEPTH),
        .TAG_W  (TAG_W),
        .ADDR_W (ADDR_W)
    ) u_retire_select (
        .i_valid    (r_valid),
        .i_finished (r_finished),
        .i_dest_en  (r_dest_en),
        .i_dest     (r_dest),
        .i_head     (r_head),
        .o_head1    (w_head1),
        .o_r0       (w_r0),
        .o_r1       (w_r1)
    );

    // Readiness looks only at the registered count; a same-cycle retire
    // frees space one cycle later, which keeps this path short.
    always_comb begin
        alloc_ready_A = (r_count < L_DEPTH);
        alloc_ready_B = (r_count < L_DM1);
        alloc_tag_A   = r_tail;
        alloc_tag_B   = r_tail + TAG_W'(alloc_en_A);
        w_acc_a       = alloc_en_A & alloc_ready_A;
        // If A is requested, B needs two free slots; otherwise one suffices.
        // A rejected A always rejects B too, since ready_B implies ready_A.
        w_acc_b       = alloc_en_B & (alloc_en_A ? alloc_ready_B : alloc_ready_A);
        w_n_alloc     = CNT_W'(w_acc_a) + CNT_W'(w_acc_b);
        w_n_ret       = CNT_W'(w_r0) + CNT_W'(w_r1);
        w_wr_a        = w_r0 & r_dest_en[r_head];
        w_wr_b        = w_r1 & r_dest_en[w_head1];
        rob_empty     = (r_count == '0);
        rob_full      = (r_count == L_DEPTH);
    end

    // Entry state, pointers and count. Finish, retire and allocate touch
    // disjoint entries: allocated slots are invalid (finish ignored) and
    // retired slots are valid (never allocation targets).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= '0;
            r_finished <= '0;
            r_dest_en  <= '0;
            r_dest     <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            if (finish_en_A && r_valid[finish_tag_A])
                r_finished[finish_tag_A] <= 1'b1;
            if (finish_en_B && r_valid[finish_tag_B])
                r_finished[finish_tag_B] <= 1'b1;
            if (w_r0) begin
                r_valid[r_head]    <= 1'b0;
                r_finished[r_head] <= 1'b0;
            end
            if (w_r1) begin
                r_valid[w_head1]    <= 1'b0;
                r_finished[w_head1] <= 1'b0;
            end
            if (w_acc_a) begin
                r_valid[alloc_tag_A]    <= 1'b1;
                r_finished[alloc_tag_A] <= 1'b0;
                r_dest_en[alloc_tag_A]  <= alloc_dest_en_A;
                r_dest[alloc_tag_A]     <= alloc_dest_A;
            end
            // When B is accepted with A, alloc_tag_B is tail+1 = A's slot + 1
            if (w_acc_b) begin
                r_valid[alloc_tag_B]    <= 1'b1;
                r_finished[alloc_tag_B] <= 1'b0;
                r_dest_en[alloc_tag_B]  <= alloc_dest_en_B;
                r_dest[alloc_tag_B]     <= alloc_dest_B;
            end
            r_head  <= r_head + TAG_W'(w_r0) + TAG_W'(w_r1);
            r_tail  <= r_tail + TAG_W'(w_acc_a) + TAG_W'(w_acc_b);
            r_count <= r_count + w_n_alloc - w_n_ret;
        end
    end

    // ARF-update strobes, one cycle after the retire decision; the address
    // is forced to zero whenever its strobe is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_upd_en_a   <= 1'b0;
            r_upd_en_b   <= 1'b0;
            r_upd_addr_a <= '0;
            r_upd_addr_b <= '0;
        end else begin
            r_upd_en_a   <= w_wr_a;
            r_upd_en_b   <= w_wr_b;
            r_upd_addr_a <= w_wr_a ? r_dest[r_head]  : '0;
            r_upd_addr_b <= w_wr_b ? r_dest[w_head1] : '0;
        end
    end

    assign updateEnA   = r_upd_en_a;
    assign updateEnB   = r_upd_en_b;
    assign updateAddrA = r_upd_addr_a;
    assign updateAddrB = r_upd_addr_b;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed, table-driven bench for reorder_buffer. Each vector holds the
// inputs for one cycle, the combinational outputs expected before the
// edge, and the update strobes expected after it.
module tb_reorder_buffer;
    logic       clk = 1'b0;
    logic       rst;
    logic       alloc_en_A, alloc_en_B, alloc_dest_en_A, alloc_dest_en_B;
    logic [4:0] alloc_dest_A, alloc_dest_B;
    logic       alloc_ready_A, alloc_ready_B;
    logic [2:0] alloc_tag_A, alloc_tag_B;
    logic       finish_en_A, finish_en_B;
    logic [2:0] finish_tag_A, finish_tag_B;
    logic       updateEnA, updateEnB;
    logic [4:0] updateAddrA, updateAddrB;
    logic       rob_empty, rob_full;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_en_A      (alloc_en_A),
        .alloc_en_B      (alloc_en_B),
        .alloc_dest_en_A (alloc_dest_en_A),
        .alloc_dest_en_B (alloc_dest_en_B),
        .alloc_dest_A    (alloc_dest_A),
        .alloc_dest_B    (alloc_dest_B),
        .alloc_ready_A   (alloc_ready_A),
        .alloc_ready_B   (alloc_ready_B),
        .alloc_tag_A     (alloc_tag_A),
        .alloc_tag_B     (alloc_tag_B),
        .finish_en_A     (finish_en_A),
        .finish_en_B     (finish_en_B),
        .finish_tag_A    (finish_tag_A),
        .finish_tag_B    (finish_tag_B),
        .updateEnA       (updateEnA),
        .updateEnB       (updateEnB),
        .updateAddrA     (updateAddrA),
        .updateAddrB     (updateAddrB),
        .rob_empty       (rob_empty),
        .rob_full        (rob_full)
    );

    typedef struct {
        logic       rst, aA, aB, deA, deB, fA, fB;
        logic [4:0] dA, dB;
        logic [2:0] ftA, ftB;
        logic [9:0]  pre;   // {tagA, tagB, readyA, readyB, empty, full}
        logic [11:0] post;  // {enA, addrA, enB, addrB}
    } vec_t;

    vec_t tbl[$];

    function automatic logic [9:0] ep(input int ta, input int tb,
                                      input logic ra, input logic rb,
                                      input logic e, input logic f);
        return {3'(ta), 3'(tb), ra, rb, e, f};
    endfunction

    function automatic logic [11:0] eu(input logic ea, input int aa,
                                       input logic eb, input int ab);
        return {ea, 5'(aa), eb, 5'(ab)};
    endfunction

    function automatic vec_t mk(input logic r, input logic aA, input logic aB,
                                input logic deA, input int dA,
                                input logic deB, input int dB,
                                input logic fA, input int ftA,
                                input logic fB, input int ftB,
                                input logic [9:0] pre, input logic [11:0] post);
        vec_t v;
        v.rst = r;  v.aA = aA;  v.aB = aB;
        v.deA = deA; v.dA = 5'(dA); v.deB = deB; v.dB = 5'(dB);
        v.fA = fA; v.ftA = 3'(ftA); v.fB = fB; v.ftB = 3'(ftB);
        v.pre = pre; v.post = post;
        return v;
    endfunction

    task automatic check(input string nm, input logic [11:0] got, input logic [11:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Drive on the falling edge, check pre-edge comb outputs, then check
    // the registered strobes just after the rising edge.
    task automatic apply(input vec_t v, input string nm);
        @(negedge clk);
        rst = v.rst;
        alloc_en_A = v.aA; alloc_en_B = v.aB;
        alloc_dest_en_A = v.deA; alloc_dest_A = v.dA;
        alloc_dest_en_B = v.deB; alloc_dest_B = v.dB;
        finish_en_A = v.fA; finish_tag_A = v.ftA;
        finish_en_B = v.fB; finish_tag_B = v.ftB;
        #1;
        check({nm, " pre"},
              {2'b00, alloc_tag_A, alloc_tag_B, alloc_ready_A, alloc_ready_B, rob_empty, rob_full},
              {2'b00, v.pre});
        @(posedge clk);
        #1;
        check({nm, " upd"}, {updateEnA, updateAddrA, updateEnB, updateAddrB}, v.post);
    endtask

    initial begin
        logic [11:0] Z;
        Z = eu(0, 0, 0, 0);
        // T1 reset state
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0,0, ep(0,0,1,1,1,0), Z));
        // T2 alloc 5/6, finish out of order, retire together
        tbl.push_back(mk(0, 1,1, 1,5, 1,6, 0,0, 0,0, ep(0,1,1,1,1,0), Z));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 1,1, 0,0, ep(2,2,1,1,0,0), Z));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 1,0, 0,0, ep(2,2,1,1,0,0), Z));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0,0, ep(2,2,1,1,0,0), eu(1,5,1,6)));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0,0, ep(2,2,1,1,1,0), Z));
        // T3 head blocking: tags 2,3,4; finish 3,4 then 2
        tbl.push_back(mk(0, 1,1, 1,10, 1,11, 0,0, 0,0, ep(2,3,1,1,1,0), Z));
        tbl.push_back(mk(0, 1,0, 1,12, 0,0, 0,0, 0,0, ep(4,5,1,1,0,0), Z));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 1,3, 1,4, ep(5,5,1,1,0,0), Z));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0,0, ep(5,5,1,1,0,0), Z));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 1,2, 0,0, ep(5,5,1,1,0,0), Z));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0,0, ep(5,5,1,1,0,0), eu(1,10,1,11)));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0,0, ep(5,5,1,1,0,0), eu(1,12,0,0)));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0,0, ep(5,5,1,1,1,0), Z));
        // T4 fill 8 from tag 5 (wraps), overflow rejected, retire 2, refill
        tbl.push_back(mk(0, 1,1, 1,1, 1,2, 0,0, 0,0, ep(5,6,1,1,1,0), Z));
        tbl.push_back(mk(0, 1,1, 1,3, 1,4, 0,0, 0,0, ep(7,0,1,1,0,0), Z));
        tbl.push_back(mk(0, 1,1, 1,5, 1,6, 0,0, 0,0, ep(1,2,1,1,0,0), Z));
        tbl.push_back(mk(0, 1,1, 1,7, 1,8, 0,0, 0,0, ep(3,4,1,1,0,0), Z));
        tbl.push_back(mk(0, 1,1, 1,9, 1,9, 0,0, 0,0, ep(5,6,0,0,0,1), Z));
        tbl.push_back(mk(0, 1,1, 1,9, 1,9, 1,5, 1,6, ep(5,6,0,0,0,1), Z));
        tbl.push_back(mk(0, 1,1, 1,9, 1,10, 0,0, 0,0, ep(5,6,0,0,0,1), eu(1,1,1,2)));
        tbl.push_back(mk(0, 1,1, 1,9, 1,10, 0,0, 0,0, ep(5,6,1,1,0,0), Z));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0,0, ep(7,7,0,0,0,1), Z));
        // drain the full buffer two per cycle across the wrap
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 1,7, 1,0, ep(7,7,0,0,0,1), Z));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 1,1, 1,2, ep(7,7,0,0,0,1), eu(1,3,1,4)));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 1,3, 1,4, ep(7,7,1,1,0,0), eu(1,5,1,6)));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 1,5, 1,6, ep(7,7,1,1,0,0), eu(1,7,1,8)));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0,0, ep(7,7,1,1,0,0), eu(1,9,1,10)));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0,0, ep(7,7,1,1,1,0), Z));
        // T5 no-dest entry (tag 7), then three entries all writing r7
        tbl.push_back(mk(0, 1,1, 0,31, 1,7, 0,0, 0,0, ep(7,0,1,1,1,0), Z));
        tbl.push_back(mk(0, 1,1, 1,7, 1,7, 0,0, 0,0, ep(1,2,1,1,0,0), Z));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 1,7, 1,0, ep(3,3,1,1,0,0), Z));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 1,1, 1,2, ep(3,3,1,1,0,0), eu(0,0,1,7)));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0,0, ep(3,3,1,1,0,0), eu(1,7,0,0)));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0,0, ep(3,3,1,1,0,0), eu(1,7,0,0)));
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0,0, ep(3,3,1,1,1,0), Z));

        // initial reset, held for two edges
        rst = 1'b1;
        alloc_en_A = 0; alloc_en_B = 0; alloc_dest_en_A = 0; alloc_dest_en_B = 0;
        alloc_dest_A = 0; alloc_dest_B = 0;
        finish_en_A = 0; finish_en_B = 0; finish_tag_A = 0; finish_tag_B = 0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("v%0d", i));

        // T6 reset mid-flight: tags 3..6 pending, 3 and 4 finished
        apply(mk(0, 1,1, 1,20, 1,21, 0,0, 0,0, ep(3,4,1,1,1,0), Z), "t6 alloc0");
        apply(mk(0, 1,1, 1,22, 1,23, 0,0, 0,0, ep(5,6,1,1,0,0), Z), "t6 alloc1");
        apply(mk(0, 0,0, 0,0, 0,0, 1,3, 1,4, ep(7,7,1,1,0,0), Z), "t6 finish");
        apply(mk(1, 0,0, 0,0, 0,0, 0,0, 0,0, ep(7,7,1,1,0,0), Z), "t6 rst");
        // stale finishes on now-invalid tags 0 and 1 must not stick
        apply(mk(0, 0,0, 0,0, 0,0, 1,0, 1,1, ep(0,0,1,1,1,0), Z), "t6 stale");
        apply(mk(0, 1,1, 1,24, 1,25, 0,0, 0,0, ep(0,1,1,1,1,0), Z), "t6 realloc");
        apply(mk(0, 0,0, 0,0, 0,0, 0,0, 0,0, ep(2,2,1,1,0,0), Z), "t6 idle");
        apply(mk(0, 0,0, 0,0, 0,0, 1,0, 0,0, ep(2,2,1,1,0,0), Z), "t6 fin0");
        apply(mk(0, 0,0, 0,0, 0,0, 0,0, 0,0, ep(2,2,1,1,0,0), eu(1,24,0,0)), "t6 ret0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
